// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: queues committed doubleword stores, drains each as an address+data bus write, forwards youngest pending data to loads.
// Latency: a store enqueued at one edge leaves IDLE at the next edge; each store costs ADDR(1)+DATA(1)+RESP(>=1) cycles on a zero-wait bus.
// Backpressure: outStall while all DEPTH entries are occupied (a same-cycle pop does not free a slot); bus beats hold until bus_reqack.
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   inMemWrite/inAddress/inData    committed store from writeback; accepted when !outStall
//   outStall, outEmpty             FIFO full / buffer fully drained and idle
//   inLookupAddr -> outLookupHit/outLookupData   combinational store-to-load forwarding
//   bus_req* / bus_resp*           two-beat write request, tagged completion handshake
module store_drain_buffer #(
    parameter int                       BUS_DATA_WIDTH = 64,
    parameter int                       BUS_TAG_WIDTH  = 13,
    parameter int                       DEPTH          = 4,
    parameter logic [BUS_TAG_WIDTH-1:0] WRITE_TAG      = 13'h1100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inMemWrite,
    input  logic [BUS_DATA_WIDTH-1:0] inAddress,
    input  logic [BUS_DATA_WIDTH-1:0] inData,
    output logic                      outStall,
    output logic                      outEmpty,
    input  logic [BUS_DATA_WIDTH-1:0] inLookupAddr,
    output logic                      outLookupHit,
    output logic [BUS_DATA_WIDTH-1:0] outLookupData,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = BUS_DATA_WIDTH - 3;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                    stateQ, stateD;
    logic [PW-1:0]             headPtr, tailPtr;
    logic [CW-1:0]             count;
    logic [AW-1:0]             memAddr [DEPTH];
    logic [BUS_DATA_WIDTH-1:0] memData [DEPTH];
    logic                      doPush, doPop;

    // Byte offset within the doubleword plays no part in storage or matching.
    logic unusedLowBits;
    assign unusedLowBits = ^{inAddress[2:0], inLookupAddr[2:0]};

    assign outStall = (count == CW'(DEPTH));
    assign outEmpty = (count == '0) && (stateQ == IDLE);
    assign doPush   = inMemWrite && !outStall;
    assign doPop    = (stateQ == RESP) && bus_respcyc && (bus_resptag == WRITE_TAG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ  <= IDLE;
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            stateQ <= stateD;
            if (doPush) tailPtr <= tailPtr + PW'(1);
            if (doPop)  headPtr <= headPtr + PW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (doPush) begin
            memAddr[tailPtr] <= inAddress[BUS_DATA_WIDTH-1:3];
            memData[tailPtr] <= inData;
        end
    end

    always_comb begin
        stateD      = stateQ;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_respack = 1'b0;
        case (stateQ)
            IDLE: if (count != '0) stateD = ADDR;
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = {memAddr[headPtr], 3'b000};
                if (bus_reqack) stateD = DATA;
            end
            DATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = memData[headPtr];
                if (bus_reqack) stateD = RESP;
            end
            RESP: begin
                // count still includes the head being retired here.
                if (doPop) begin
                    bus_respack = 1'b1;
                    stateD      = (count > CW'(1)) ? ADDR : IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign bus_reqtag = bus_reqcyc ? WRITE_TAG : '0;

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        outLookupHit  = 1'b0;
        outLookupData = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) &&
                (memAddr[headPtr + PW'(k)] == inLookupAddr[BUS_DATA_WIDTH-1:3])) begin
                outLookupHit  = 1'b1;
                outLookupData = memData[headPtr + PW'(k)];
            end
        end
    end
endmodule
